uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_arb_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 95 +++++++++
 tb/tb_uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default requester count.
// Optional feature macro used by the arbiter: UART_ARB_RR_EN (round-robin arbitration).
package uart_pkg;

   localparam int UART_N_REQ_DEF = 4;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_GRANT     = 2'd1;
   localparam logic [1:0] ST_START     = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      GRANT     = ST_GRANT,
      START     = ST_START,
      WAIT_DONE = ST_WAIT_DONE
   } uart_arb_state_t;

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner selection: first asserted request found when scanning upward from ptr.
// A ptr tied to zero gives fixed priority with req[0] highest.
module uart_arb_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   // Scan from the farthest candidate down so the one nearest ptr is written last and wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         int j;
         j = (int'(ptr) + k) % N_REQ;
         if (req[j]) begin
            valid = 1'b1;
            idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte senders onto one UART transmitter: grant, start pulse, wait for frame done.
// Define UART_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with req[0] highest.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = UART_N_REQ_DEF,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   gnt,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   input  logic               tx_done,
   output logic               arb_busy,
   output logic [IDX_W-1:0]   cur_idx
);

   // Handshake: a requester holds req (and its byte) high until it sees its one-cycle gnt pulse;
   // the byte is captured on that same edge, so req/data may change freely afterwards.

   uart_arb_state_t  state;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [7:0]       pick_byte;
   logic [IDX_W-1:0] ptr;

`ifdef UART_ARB_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (state == IDLE && pick_valid && !tx_busy) begin
         ptr <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
   end
`else
   assign ptr = '0;
`endif

   uart_arb_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign pick_byte = req_data[{pick_idx, 3'b000} +: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         arb_busy <= 1'b0;
         cur_idx  <= '0;
      end else begin
         gnt      <= '0;
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid && !tx_busy) begin
                  gnt      <= N_REQ'(1) << pick_idx;
                  tx_data  <= pick_byte;
                  cur_idx  <= pick_idx;
                  arb_busy <= 1'b1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               tx_start <= 1'b1;
               state    <= START;
            end
            START: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // tx_data and cur_idx stay untouched until the next grant.
               if (tx_done) begin
                  arb_busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4); honours UART_ARB_RR_EN for the grant-order check.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done;
   logic        arb_busy;
   logic [1:0]  cur_idx;

   int n_cmp;
   int n_err;

   uart_tx_arbiter #(.N_REQ(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .arb_busy (arb_busy),
      .cur_idx  (cur_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'h0);
      chk({tag, "_start"}, 32'(tx_start), 32'h0);
      chk({tag, "_data"}, 32'(tx_data), 32'h0);
      chk({tag, "_busy"}, 32'(arb_busy), 32'h0);
      chk({tag, "_idx"}, 32'(cur_idx), 32'h0);
   endtask

   int exp_order[5];

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      req      = 4'b0000;
      req_data = 32'h0;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
`ifdef UART_ARB_RR_EN
      exp_order = '{0, 1, 2, 3, 0};
`else
      exp_order = '{0, 0, 0, 0, 0};
`endif

      // Reset state
      #1;
      chk_all_zero("reset");
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("idle_gnt", 32'(gnt), 32'h0);

      // Single request on requester 2
      req      = 4'b0100;
      req_data = 32'h0041_0000;
      tick();
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_busy", 32'(arb_busy), 32'h1);
      chk("single_idx", 32'(cur_idx), 32'h2);
      chk("single_nostart", 32'(tx_start), 32'h0);
      req = 4'b0000;
      tick();
      chk("single_start", 32'(tx_start), 32'h1);
      chk("single_data", 32'(tx_data), 32'h41);
      chk("single_gnt_off", 32'(gnt), 32'h0);
      tick();
      chk("single_start_off", 32'(tx_start), 32'h0);
      tick();
      tick();
      chk("single_busy_wait", 32'(arb_busy), 32'h1);
      chk("single_data_wait", 32'(tx_data), 32'h41);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("single_done", 32'(arb_busy), 32'h0);

      // Transmitter busy holds off the grant
      tx_busy = 1'b1;
      req     = 4'b0010;
      tick();
      chk("busy_hold1", 32'(gnt), 32'h0);
      tick();
      tick();
      chk("busy_hold3", 32'(gnt), 32'h0);
      chk("busy_hold_arb", 32'(arb_busy), 32'h0);
      tx_busy = 1'b0;
      tick();
      chk("busy_release_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      tick();
      chk("busy_start", 32'(tx_start), 32'h1);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("busy_done", 32'(arb_busy), 32'h0);

      // Spurious tx_done in IDLE and in GRANT
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("spur_idle_gnt", 32'(gnt), 32'h0);
      chk("spur_idle_busy", 32'(arb_busy), 32'h0);
      req = 4'b0001;
      tick();
      chk("spur_gnt", 32'(gnt), 32'h1);
      req     = 4'b0000;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("spur_grant_start", 32'(tx_start), 32'h1);
      chk("spur_grant_busy", 32'(arb_busy), 32'h1);
      tick();
      tick();
      chk("spur_wait_busy", 32'(arb_busy), 32'h1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("spur_done", 32'(arb_busy), 32'h0);

      // Requester 3 changes its byte after the grant
      req      = 4'b1000;
      req_data = 32'h3000_0000;
      tick();
      chk("hold_gnt", 32'(gnt), 32'h8);
      chk("hold_data_g", 32'(tx_data), 32'h30);
      req_data = 32'h3100_0000;
      tick();
      chk("hold_data_s", 32'(tx_data), 32'h30);
      req = 4'b0000;
      tick();
      chk("hold_data_w", 32'(tx_data), 32'h30);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("hold_data_end", 32'(tx_data), 32'h30);
      chk("hold_idx", 32'(cur_idx), 32'h3);

      // All four requesting: grant order across five frames
      req      = 4'b1111;
      req_data = 32'hD3C2_B1A0;
      for (int f = 0; f < 5; f++) begin
         tick();
         chk($sformatf("order_gnt%0d", f), 32'(gnt), 32'(1) << exp_order[f]);
         chk($sformatf("order_idx%0d", f), 32'(cur_idx), 32'(exp_order[f]));
         tick();
         chk($sformatf("order_start%0d", f), 32'(tx_start), 32'h1);
         chk($sformatf("order_data%0d", f), 32'(tx_data), 32'hA0 + 32'h11 * 32'(exp_order[f]));
         tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end

      // Reset mid-WAIT_DONE
      tick();
      chk("rstmid_gnt", 32'(|gnt), 32'h1);
      tick();
      tick();
      chk("rstmid_busy", 32'(arb_busy), 32'h1);
      rst = 1'b1;
      #1;
      chk_all_zero("rstmid");
      tick();
      chk("rstmid_hold_gnt", 32'(gnt), 32'h0);
      chk("rstmid_hold_start", 32'(tx_start), 32'h0);
      rst = 1'b0;
      tick();
      chk("rstmid_first_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      tick();
      chk("rstmid_first_start", 32'(tx_start), 32'h1);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("rstmid_done", 32'(arb_busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
